// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu : memory-access stage of the five-stage MIPS pipeline.
//
// Sits between the EX/MEM and MEM/WB pipeline registers. Byte, halfword and
// word loads and stores go to a data RAM over a req/ack handshake. The stage
// holds the pipeline with stallreq_o until the access completes. Non-memory
// operations pass straight through combinationally with no added latency.
// Byte order is big-endian: byte offset 0 is bits [31:24] and sel bit 3.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   Defined   - adds align_exc_o. A misaligned halfword or word access raises
//               it for one IDLE cycle and issues no RAM request.
//   Undefined - no check is made. The low address bits pick lanes as if the
//               access were aligned.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wd_i/wd_o       destination register address (EX/MEM -> MEM/WB)
//   wreg_i/wreg_o   register write enable
//   wdata_i/wdata_o ALU result in, writeback data out
//   aluop_i         operation code
//   mem_addr_i      effective byte address
//   mem_sdata_i     store data, right-aligned
//   stallreq_o      stall request to pipeline control
//   ram_*           data RAM request channel (req/we/addr/sel/wdata, rdata/ack)
//   align_exc_o     misaligned-access flag (MEM_ALIGN_CHECK_EN only)
// ---------------------------------------------------------------------------
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              align_exc_o,
`endif
    input  logic              ram_ack_i
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e      state_q, state_d;
    logic [31:0] ld_q, ld_d;

    logic        is_load, is_store, is_signed;
    size_e       size;
    logic [1:0]  off;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_ext;
    logic        misalign;

    assign off = mem_addr_i[1:0];

    // Opcode decode.
    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        case (aluop_i)
            OP_LB:  begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_B; end
            OP_LH:  begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_H; end
            OP_LW:  begin is_load  = 1'b1;                   size = SZ_W; end
            OP_LBU: begin is_load  = 1'b1;                   size = SZ_B; end
            OP_LHU: begin is_load  = 1'b1;                   size = SZ_H; end
            OP_SB:  begin is_store = 1'b1;                   size = SZ_B; end
            OP_SH:  begin is_store = 1'b1;                   size = SZ_H; end
            OP_SW:  begin is_store = 1'b1;                   size = SZ_W; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((size == SZ_H) && mem_addr_i[0]) ||
                      ((size == SZ_W) && (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Byte-lane enables and replicated store data. Halfword uses addr[1]
    // alone and word ignores the low bits, so misaligned accesses stay sane
    // when the check is compiled out.
    always_comb begin
        case (size)
            SZ_B: begin
                lane_sel   = 4'b1000 >> off;
                lane_wdata = {4{mem_sdata_i[7:0]}};
            end
            SZ_H: begin
                lane_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{mem_sdata_i[15:0]}};
            end
            default: begin
                lane_sel   = 4'b1111;
                lane_wdata = mem_sdata_i;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the load data.
    always_comb begin
        case (off)
            2'd0:    byte_v = ram_rdata_i[31:24];
            2'd1:    byte_v = ram_rdata_i[23:16];
            2'd2:    byte_v = ram_rdata_i[15:8];
            default: byte_v = ram_rdata_i[7:0];
        endcase
        half_v = mem_addr_i[1] ? ram_rdata_i[15:0] : ram_rdata_i[31:16];
        case (size)
            SZ_B:    ld_ext = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_H:    ld_ext = {{16{is_signed & half_v[15]}}, half_v};
            default: ld_ext = ram_rdata_i;
        endcase
    end

    // Next state and outputs.
    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_sel_o   = 4'b0000;
        ram_wdata_o = 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
        align_exc_o = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (is_load || is_store) begin
                    // No writeback while the access is outstanding.
                    wreg_o = 1'b0;
                    if (misalign) begin
`ifdef MEM_ALIGN_CHECK_EN
                        align_exc_o = 1'b1;
`endif
                    end else begin
                        stallreq_o  = 1'b1;
                        ram_req_o   = 1'b1;
                        ram_we_o    = is_store;
                        ram_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        ram_sel_o   = lane_sel;
                        ram_wdata_o = lane_wdata;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // EX/MEM is frozen, so the request fields stay stable here.
                wreg_o      = 1'b0;
                stallreq_o  = 1'b1;
                ram_req_o   = 1'b1;
                ram_we_o    = is_store;
                ram_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                ram_sel_o   = lane_sel;
                ram_wdata_o = lane_wdata;
                if (ram_ack_i) begin
                    ld_d    = ld_ext;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Request drops here, so back-to-back ops get a one-cycle gap.
                if (is_load) begin
                    wdata_o = ld_q;
                end else if (is_store) begin
                    wreg_o = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset forces every output low for the cycle it is held.
        if (rst) begin
            wd_o        = 5'd0;
            wreg_o      = 1'b0;
            wdata_o     = 32'h0;
            stallreq_o  = 1'b0;
            ram_req_o   = 1'b0;
            ram_we_o    = 1'b0;
            ram_addr_o  = '0;
            ram_sel_o   = 4'b0000;
            ram_wdata_o = 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
            align_exc_o = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ld_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
        end
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. Performs byte, halfword and word loads and stores against a data RAM with a req/ack handshake, and holds the pipeline through `stallreq_o` until the access completes. Non-memory instructions pass straight through with zero added latency.

## Interface
Parameters:
- `ADDR_W`, 32: data address width.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `wd_i`, in, 5: destination register address from EX/MEM.
- `wreg_i`, in, 1: write-enable from EX/MEM.
- `wdata_i`, in, 32: ALU result from EX/MEM.
- `aluop_i`, in, 8: operation code from EX/MEM.
- `mem_addr_i`, in, ADDR_W: effective address.
- `mem_sdata_i`, in, 32: store data, right-aligned.
- `wd_o`, out, 5: destination register address to MEM/WB.
- `wreg_o`, out, 1: write-enable to MEM/WB.
- `wdata_o`, out, 32: writeback data to MEM/WB.
- `stallreq_o`, out, 1: stall request to pipeline control.
- `ram_req_o`, out, 1: RAM request.
- `ram_we_o`, out, 1: 1 = write, 0 = read.
- `ram_addr_o`, out, ADDR_W: word address, `{mem_addr_i[ADDR_W-1:2],2'b00}`.
- `ram_sel_o`, out, 4: byte-lane enables; bit 3 = bits [31:24].
- `ram_wdata_o`, out, 32: lane-replicated store data.
- `ram_rdata_i`, in, 32: read data, valid when `ram_ack_i` is high.
- `ram_ack_i`, in, 1: access complete.

## Operation
- Opcodes: LB `8'hE0`, LH `8'hE1`, LW `8'hE3`, LBU `8'hE4`, LHU `8'hE5`, SB `8'hE8`, SH `8'hE9`, SW `8'hEB`. Every other value is a non-memory op.
- Byte order is big-endian.
  - Byte lanes: offset 0 maps to sel `1000` and bits [31:24]; offset 3 maps to `0001`.
  - Halfword lanes: offset 0 maps to `1100`, offset 2 maps to `0011`.
  - Word: `1111`.
- Stores replicate data across lanes: SB uses `{4{b}}`, SH uses `{2{h}}`.
- Loads extract the selected lane.
  - LB and LH sign-extend to 32 bits.
  - LBU and LHU zero-extend.
- The FSM has three states.
  - IDLE:
    - Non-memory op: outputs equal inputs; `ram_req_o` = 0; `stallreq_o` = 0.
    - Memory op: `ram_req_o` = 1 and `stallreq_o` = 1. Next state is WAIT.
  - WAIT:
    - `ram_req_o`, `stallreq_o`, address, sel, we and wdata stay asserted and stable.
    - On `ram_ack_i`: the extended load data is captured into `ld_q`, and the next state is DONE.
  - DONE: `ram_req_o` = 0 and `stallreq_o` = 0.
    - Loads drive `wreg_o = wreg_i` and `wdata_o = ld_q`.
    - Stores drive `wreg_o` = 0.
    - Next state is IDLE.
- In IDLE and WAIT with a memory op, `wreg_o` = 0, so no partial writeback occurs while stalled.
- `ram_ack_i` is ignored outside WAIT.

## Timing
- Reset: while `rst` is high, all outputs are 0 (`wd_o` = 5'd0, `wdata_o` = 32'h0) and the state goes to IDLE on the next edge.
  - Reset during WAIT abandons the access. A late `ram_ack_i` is then ignored.
- Non-memory op: 0-cycle combinational pass-through.
- Memory op, with ack in the first WAIT cycle: 3 cycles.
  - `stallreq_o` is high for 2 cycles.
  - The result is presented in the DONE cycle and captured by MEM/WB on the following edge.
- Each extra wait cycle adds 1.
- The RAM must not assert ack in the same cycle the request first rises; that cycle is the IDLE cycle.
- Pipeline control freezes EX/MEM while `stallreq_o` is high, so `*_i` are stable from IDLE through DONE.
- Back-to-back memory ops: after DONE, the next op enters IDLE one cycle later. No request is issued in the DONE cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: adds output `align_exc_o` (1 bit).
  - A halfword access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, is misaligned.
  - A misaligned access issues no RAM request.
  - In IDLE it drives `stallreq_o` = 0, `wreg_o` = 0 and `align_exc_o` = 1, combinationally for that cycle. The state stays IDLE.
- Undefined: no check is made and the port does not exist.
  - Low address bits select lanes as if aligned: halfword uses `addr[1]`; word ignores `addr[1:0]`.

## Test plan
- Reset, then ADD pass-through: `wd_i`=5, `wreg_i`=1, `wdata_i`=32'h1234 -> same on the outputs in the same cycle; `stallreq_o`=0; `ram_req_o`=0.
- LB at addr 0x101 with RAM word 32'h11F2_3344, ack after 1 WAIT cycle -> `ram_sel_o`=0100, `stallreq_o` high for 2 cycles, DONE `wdata_o`=32'hFFFF_FFF2. The same access with LBU gives 32'h0000_00F2.
- SH at addr 0x202, `mem_sdata_i`=32'hABCD_1234, ack after 3 WAIT cycles -> `ram_we_o`=1, `ram_sel_o`=0011, `ram_wdata_o`=32'h1234_1234, `stallreq_o` high for 4 cycles, `wreg_o`=0 throughout.
- `rst` asserted in WAIT of an LW; ack arrives 2 cycles later -> outputs are 0 from the reset cycle on, state is IDLE, and the ack causes no writeback.
- Back-to-back LW at 0x0 then SW at 0x4, each with 1-cycle ack -> two separate request windows separated by the DONE cycle; the LW writeback equals the RAM word.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x3 -> `align_exc_o`=1, `ram_req_o`=0, `stallreq_o`=0, `wreg_o`=0.
